// File: rtl/spi_nibble_writer_if.sv
// -----------------------------------------------------------------------------
// spi_nibble_writer_if
// Bundles the SPI pins from the host and the 4-bit sample RAM write port with
// the frame status outputs of spi_nibble_writer.
//
// Signals
//   spi_sclk      SPI clock from the host (asynchronous to the system clock)
//   spi_cs_n      SPI chip select, active low (asynchronous)
//   spi_mosi      SPI data, host -> writer (asynchronous)
//   spi_miso      SPI data, writer -> host
//   address[7:0]  RAM write address
//   data[3:0]     RAM write data
//   wren          RAM write enable, one-cycle pulse per nibble
//   nibble_count  nibbles written in the current/last frame
//   frame_done    one-cycle pulse after chip select deasserts
//   overflow      sticky flag: the frame carried more nibbles than accepted
//
// Modports
//   slave   the writer side (spi_nibble_writer)
//   master  the host/RAM side (testbench or surrounding system)
// -----------------------------------------------------------------------------
interface spi_nibble_writer_if;
   logic       spi_sclk;
   logic       spi_cs_n;
   logic       spi_mosi;
   logic       spi_miso;
   logic [7:0] address;
   logic [3:0] data;
   logic       wren;
   logic [7:0] nibble_count;
   logic       frame_done;
   logic       overflow;

   modport slave (
      input  spi_sclk, spi_cs_n, spi_mosi,
      output spi_miso, address, data, wren, nibble_count, frame_done, overflow
   );

   modport master (
      output spi_sclk, spi_cs_n, spi_mosi,
      input  spi_miso, address, data, wren, nibble_count, frame_done, overflow
   );
endinterface

// File: rtl/spi_nibble_writer.sv
// -----------------------------------------------------------------------------
// spi_nibble_writer
// SPI mode-0 slave that receives MSB-first bytes from the host, splits each
// byte into two nibbles (high first) and writes them into the 4-bit sample RAM
// starting at BASE_ADDR. One chip-select low window is one frame; at most
// MAX_NIBBLES nibbles are written per frame, later ones are dropped and flagged.
//
// Ports
//   clock   system clock, all logic on the rising edge (>= 6x spi_sclk)
//   reset   synchronous, active-high reset
//   bus     spi_nibble_writer_if.slave: SPI pins, RAM write port, frame status
//
// Parameters
//   BASE_ADDR    first RAM address written in each frame
//   MAX_NIBBLES  nibbles accepted per frame
//   SYNC_STAGES  synchroniser depth on the SPI inputs (>= 2)
//
// Configuration macro
//   SPI_MISO_ECHO_EN  when defined, MISO echoes the previously received byte
//                     (00 during the first byte of a frame); otherwise MISO
//                     is tied low and no echo register exists.
// -----------------------------------------------------------------------------
module spi_nibble_writer #(
   parameter logic [7:0] BASE_ADDR   = 8'h00,
   parameter logic [7:0] MAX_NIBBLES = 8'h91,
   parameter int         SYNC_STAGES = 2
) (
   input logic                clock,
   input logic                reset,
   spi_nibble_writer_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RECV,
      S_WR_HI,
      S_WR_LO,
      S_DONE
   } state_t;

   // ---------------------------------------------------------------------------
   // Input synchronisers and edge detection
   // ---------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] r_sclk_sync;
   logic [SYNC_STAGES-1:0] r_cs_sync;
   logic [SYNC_STAGES-1:0] r_mosi_sync;
   logic                   r_sclk_d;
   logic                   r_cs_d;

   // NOTE: the synchronisers and edge-detect flops are deliberately not reset.
   // They keep tracking the pins through reset, so a reset in the middle of a
   // frame cannot manufacture a chip-select edge when it releases.
   always_ff @(posedge clock) begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.spi_sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0],   bus.spi_cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
      r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
      r_cs_d      <= r_cs_sync[SYNC_STAGES-1];
   end

   logic w_sclk;
   logic w_cs_n;
   logic w_mosi;
   logic w_sclk_rise;
   logic w_cs_fall;
   logic w_cs_rise;

   assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
   assign w_cs_n      = r_cs_sync[SYNC_STAGES-1];
   assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
   assign w_sclk_rise = w_sclk & ~r_sclk_d;
   assign w_cs_fall   = ~w_cs_n & r_cs_d;
   assign w_cs_rise   = w_cs_n & ~r_cs_d;

   // ---------------------------------------------------------------------------
   // Byte shifter: independent of the write FSM so the next byte can arrive
   // while the previous one is still being written.
   // ---------------------------------------------------------------------------
   logic       r_in_frame;   // set only by a real cs_n fall seen after reset
   logic [2:0] r_bit_cnt;
   logic [6:0] r_shift;
   logic [7:0] r_hold;
   logic       r_byte_rdy;
   logic [7:0] w_shift_next;

   assign w_shift_next = {r_shift, w_mosi};

   // NOTE: sequential state is always assigned with non-blocking (<=) so every
   // flop samples the pre-edge values of the others, independent of order.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_in_frame <= 1'b0;
         r_bit_cnt  <= 3'd0;
         r_shift    <= 7'd0;
         r_hold     <= 8'h00;
         r_byte_rdy <= 1'b0;
      end else begin
         r_byte_rdy <= 1'b0;
         if (w_cs_fall) begin
            r_in_frame <= 1'b1;
            r_bit_cnt  <= 3'd0;
         end else if (w_cs_rise) begin
            // Any partial byte is simply abandoned.
            r_in_frame <= 1'b0;
            r_bit_cnt  <= 3'd0;
         end else if (r_in_frame && w_sclk_rise) begin
            r_shift <= w_shift_next[6:0];
            if (r_bit_cnt == 3'd7) begin
               r_hold     <= w_shift_next;
               r_byte_rdy <= 1'b1;
               r_bit_cnt  <= 3'd0;
            end else begin
               r_bit_cnt <= r_bit_cnt + 3'd1;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Write FSM
   // ---------------------------------------------------------------------------
   state_t     r_state;
   state_t     w_state_next;
   logic       w_wren;
   logic       w_drop;
   logic [3:0] w_data;
   logic       w_frame_done;
   logic       w_room;
   logic [7:0] r_address;
   logic [7:0] r_nibble_count;
   logic       r_overflow;

   assign w_room = (r_nibble_count < MAX_NIBBLES);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // NOTE: every signal driven here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      w_state_next = r_state;
      w_wren       = 1'b0;
      w_drop       = 1'b0;
      w_data       = 4'h0;
      w_frame_done = 1'b0;
      case (r_state)
         S_IDLE: begin
            // A byte_rdy here is stale and ignored; only a frame start matters.
            if (w_cs_fall) w_state_next = S_RECV;
         end
         S_RECV: begin
            if (r_byte_rdy)  w_state_next = S_WR_HI;
            else if (w_cs_n) w_state_next = S_DONE;
         end
         S_WR_HI: begin
            if (w_room) begin
               w_wren = 1'b1;
               w_data = r_hold[7:4];
            end else begin
               w_drop = 1'b1;
            end
            w_state_next = S_WR_LO;
         end
         S_WR_LO: begin
            if (w_room) begin
               w_wren = 1'b1;
               w_data = r_hold[3:0];
            end else begin
               w_drop = 1'b1;
            end
            // A cs_n rise during the byte write is honoured once both nibbles are done.
            w_state_next = w_cs_n ? S_DONE : S_RECV;
         end
         S_DONE: begin
            w_frame_done = 1'b1;
            w_state_next = w_cs_fall ? S_RECV : S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // Address/count/overflow: cleared at frame start, held after the frame ends.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_address      <= BASE_ADDR;
         r_nibble_count <= 8'h00;
         r_overflow     <= 1'b0;
      end else if (w_cs_fall) begin
         r_address      <= BASE_ADDR;
         r_nibble_count <= 8'h00;
         r_overflow     <= 1'b0;
      end else if (w_wren) begin
         r_address      <= r_address + 8'd1;
         r_nibble_count <= r_nibble_count + 8'd1;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end
   end

   assign bus.address      = r_address;
   assign bus.data         = w_data;
   assign bus.wren         = w_wren;
   assign bus.nibble_count = r_nibble_count;
   assign bus.frame_done   = w_frame_done;
   assign bus.overflow     = r_overflow;

   // ---------------------------------------------------------------------------
   // Optional MISO echo of the previous byte
   // ---------------------------------------------------------------------------
`ifdef SPI_MISO_ECHO_EN
   logic       w_sclk_fall;
   logic [7:0] r_miso_sh;
   logic       r_echo_skip;

   assign w_sclk_fall = ~w_sclk & r_sclk_d;

   // The byte is reloaded just after the 8th rising edge; the 8th falling edge
   // that follows must not shift, or the echoed MSB would be lost.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_miso_sh   <= 8'h00;
         r_echo_skip <= 1'b0;
      end else if (w_cs_fall) begin
         r_miso_sh   <= 8'h00;
         r_echo_skip <= 1'b0;
      end else if (r_byte_rdy) begin
         r_miso_sh   <= r_hold;
         r_echo_skip <= 1'b1;
      end else if (r_in_frame && w_sclk_fall) begin
         if (r_echo_skip) begin
            r_echo_skip <= 1'b0;
         end else begin
            r_miso_sh <= {r_miso_sh[6:0], 1'b0};
         end
      end
   end

   assign bus.spi_miso = r_miso_sh[7];
`else
   assign bus.spi_miso = 1'b0;
`endif

endmodule
